// File: rtl/i2s_rx_framer.sv
// I2S receiver: deserialises sdata_i into left/right words, publishes only complete well-formed stereo pairs.
// Latency: last right data bit to pktChanged_o is SLOT_BITS-WIDTH cycles; no backpressure, the serial stream is never stalled.
module i2s_rx_framer #(
    parameter int WIDTH     = 16,
    parameter int SLOT_BITS = 32
) (
    input  logic             sclk_i,
    input  logic             rst_i,
    input  logic             ws_i,
    input  logic             sdata_i,
    output logic [WIDTH-1:0] leftChan_o,
    output logic [WIDTH-1:0] rightChan_o,
    output logic             pktChanged_o,
    output logic             locked_o,
    output logic             frameErr_o
);

    localparam int CW = $clog2(SLOT_BITS + 1);
    localparam logic [CW-1:0] C_LAST  = CW'(SLOT_BITS - 1);
    localparam logic [CW-1:0] C_SAT   = CW'(SLOT_BITS);
    localparam logic [CW-1:0] C_WIDTH = CW'(WIDTH);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_ws_d;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt;
    logic [WIDTH-1:0] r_left_shift;
    logic [WIDTH-1:0] r_right_shift;
    logic [WIDTH-1:0] r_left_hold;
    logic [WIDTH-1:0] r_left_chan;
    logic [WIDTH-1:0] r_right_chan;
    logic             r_pkt_changed;
    logic             r_locked;
    logic             r_frame_err;

    logic w_edge;
    logic w_fall;
    logic w_rise;
    logic w_slot_ok;
    logic w_capture;
    logic w_publish;
    logic w_err;
    logic w_latch_left;

    assign w_edge    = ws_i ^ r_ws_d;
    assign w_fall    = w_edge & ~ws_i;
    assign w_rise    = w_edge & ws_i;
    // r_cnt is the position of the previous cycle, so a full slot closes at SLOT_BITS-1
    assign w_slot_ok = (r_cnt == C_LAST);

    always_comb begin
        w_cnt = r_cnt;
        if (w_edge) begin
            w_cnt = '0;
        end else if (r_cnt != C_SAT) begin
            w_cnt = r_cnt + CW'(1);
        end
    end

    // Position 0 is the I2S delay bit; positions past WIDTH are padding
    assign w_capture = (w_cnt >= CW'(1)) && (w_cnt <= C_WIDTH);

    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_publish    = 1'b0;
        w_err        = 1'b0;
        w_latch_left = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (w_fall) begin
                    w_state_nxt = ST_LEFT;
                end
            end
            ST_LEFT: begin
                if (w_rise && w_slot_ok) begin
                    w_latch_left = 1'b1;
                    w_state_nxt  = ST_RIGHT;
                end else if (w_edge || (w_cnt == C_SAT)) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_HUNT;
                end
            end
            ST_RIGHT: begin
                if (w_fall && w_slot_ok) begin
                    w_publish   = 1'b1;
                    w_state_nxt = ST_LEFT;
                end else if (w_fall) begin
                    // A short right slot still marks a valid left-slot start
                    w_err       = 1'b1;
                    w_state_nxt = ST_LEFT;
                end else if (w_edge || (w_cnt == C_SAT)) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_HUNT;
                end
            end
            default: begin
                w_state_nxt = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            r_ws_d        <= 1'b0;
            r_cnt         <= '0;
            r_left_shift  <= '0;
            r_right_shift <= '0;
            r_left_hold   <= '0;
            r_left_chan   <= '0;
            r_right_chan  <= '0;
            r_pkt_changed <= 1'b0;
            r_locked      <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_ws_d        <= ws_i;
            r_cnt         <= w_cnt;
            r_pkt_changed <= w_publish;
            r_frame_err   <= w_err;
            if (w_capture && (r_state == ST_LEFT)) begin
                r_left_shift <= {r_left_shift[WIDTH-2:0], sdata_i};
            end
            if (w_capture && (r_state == ST_RIGHT)) begin
                r_right_shift <= {r_right_shift[WIDTH-2:0], sdata_i};
            end
            if (w_latch_left) begin
                r_left_hold <= r_left_shift;
            end
            if (w_publish) begin
                r_left_chan  <= r_left_hold;
                r_right_chan <= r_right_shift;
                r_locked     <= 1'b1;
            end
            if (w_err) begin
                r_locked <= 1'b0;
            end
        end
    end

    assign leftChan_o   = r_left_chan;
    assign rightChan_o  = r_right_chan;
    assign pktChanged_o = r_pkt_changed;
    assign locked_o     = r_locked;
    assign frameErr_o   = r_frame_err;

endmodule

// File: tb/tb_i2s_rx_framer.sv
// Bench for i2s_rx_framer: ws/data stream described as a list of slots, expected pulses derived per slot.
// Expected events carry their cycle number; a negedge monitor pops and compares them.
module tb_i2s_rx_framer;
    localparam int W = 16;
    localparam int S = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ws  = 1'b0;
    logic         sd  = 1'b0;
    logic [W-1:0] lc;
    logic [W-1:0] rc;
    logic         pkt;
    logic         lk;
    logic         ferr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        bit           is_err;
        logic [W-1:0] l;
        logic [W-1:0] r;
        bit           lk;
        int           at;
    } ev_t;

    typedef struct {
        bit           rst;
        bit           v;
        int           len;
        logic [W-1:0] w;
    } seg_t;

    ev_t  exp_q[$];
    seg_t segs[$];

    // Reference: 0 = hunting, 1 = in left slot, 2 = in right slot
    int           m_state = 0;
    bit           m_prev  = 1'b0;
    int           m_plen  = 0;
    logic [W-1:0] m_pw    = '0;
    logic [W-1:0] m_hold  = '0;
    logic [W-1:0] m_outl  = '0;
    logic [W-1:0] m_outr  = '0;
    bit           m_lk    = 1'b0;

    i2s_rx_framer #(.WIDTH(W), .SLOT_BITS(S)) dut (
        .sclk_i      (clk),
        .rst_i       (rst),
        .ws_i        (ws),
        .sdata_i     (sd),
        .leftChan_o  (lc),
        .rightChan_o (rc),
        .pktChanged_o(pkt),
        .locked_o    (lk),
        .frameErr_o  (ferr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic void push_err(input int at);
        ev_t e;
        m_lk     = 1'b0;
        e.is_err = 1'b1;
        e.l      = m_outl;
        e.r      = m_outr;
        e.lk     = 1'b0;
        e.at     = at;
        exp_q.push_back(e);
    endfunction

    function automatic void push_pub(input int at);
        ev_t e;
        m_outl   = m_hold;
        m_outr   = m_pw;
        m_lk     = 1'b1;
        e.is_err = 1'b0;
        e.l      = m_outl;
        e.r      = m_outr;
        e.lk     = 1'b1;
        e.at     = at;
        exp_q.push_back(e);
    endfunction

    // Slot-level rules: a slot is good only if exactly S cycles long
    function automatic void model(input seg_t s, input int p0);
        if (s.rst) begin
            m_state = 0;
            m_prev  = 1'b0;
            m_outl  = '0;
            m_outr  = '0;
            m_lk    = 1'b0;
            return;
        end
        if (s.v != m_prev) begin
            case (m_state)
                0: if (!s.v) m_state = 1;
                1: begin
                    if (s.v && m_plen == S) begin
                        m_hold  = m_pw;
                        m_state = 2;
                    end else begin
                        push_err(p0);
                        m_state = 0;
                    end
                end
                default: begin
                    if (!s.v) begin
                        if (m_plen == S) push_pub(p0);
                        else push_err(p0);
                        m_state = 1;
                    end else begin
                        push_err(p0);
                        m_state = 0;
                    end
                end
            endcase
        end
        if (m_state != 0 && s.len > S) begin
            push_err(p0 + S);
            m_state = 0;
        end
        m_prev = s.v;
        m_plen = s.len;
        m_pw   = s.w;
    endfunction

    function automatic void add(input bit r, input bit v, input int len, input logic [W-1:0] w);
        seg_t s;
        s.rst = r;
        s.v   = v;
        s.len = len;
        s.w   = w;
        segs.push_back(s);
    endfunction

    function automatic void good(input logic [W-1:0] l, input logic [W-1:0] r);
        add(1'b0, 1'b0, S, l);
        add(1'b0, 1'b1, S, r);
    endfunction

    function automatic logic [W-1:0] rnd();
        return W'($urandom);
    endfunction

    always @(negedge clk) begin
        ev_t e;
        if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            e = exp_q.pop_front();
            chk("missed_event_cycle", cyc, e.at);
        end
        if (pkt || ferr) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {30'b0, pkt, ferr}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", {30'b0, pkt, ferr}, e.is_err ? 32'd1 : 32'd2);
                chk("event_cycle", cyc, e.at);
                chk("left_out", lc, e.l);
                chk("right_out", rc, e.r);
                chk("locked", lk, e.lk);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        bit curv;
        add(1'b1, 1'b0, 3, '0);
        // Frame 1 starts without a falling edge, so pairs appear from frame 2 on
        repeat (3) good(16'hA5C3, 16'h1234);
        good(16'h8000, 16'h7FFF);
        good(rnd(), rnd());
        good(rnd(), rnd());
        // Short right slot ending on a falling edge
        add(1'b0, 1'b0, S, rnd());
        add(1'b0, 1'b1, 20, rnd());
        good(rnd(), rnd());
        good(rnd(), rnd());
        // ws stuck low in left slot
        add(1'b0, 1'b0, 40, rnd());
        add(1'b0, 1'b1, S, rnd());
        good(rnd(), rnd());
        good(rnd(), rnd());
        // ws held high out of reset
        add(1'b1, 1'b1, 3, '0);
        add(1'b0, 1'b1, 10, rnd());
        good(rnd(), rnd());
        good(rnd(), rnd());
        // Reset at position 8 of a right slot
        add(1'b0, 1'b0, S, rnd());
        add(1'b0, 1'b1, 8, rnd());
        add(1'b1, 1'b1, 1, '0);
        add(1'b0, 1'b1, 23, rnd());
        good(rnd(), rnd());
        good(rnd(), rnd());
        curv = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 14) == 0) begin
                add(1'b1, curv, $urandom_range(1, 3), '0);
            end else begin
                curv = ~curv;
                add(1'b0, curv, ($urandom_range(0, 4) == 0) ? $urandom_range(2, 40) : S, rnd());
            end
        end
        add(1'b0, ~curv, S, rnd());
        add(1'b1, ~curv, 2, '0);

        foreach (segs[n]) begin
            for (int i = 0; i < segs[n].len; i++) begin
                @(negedge clk);
                if (i == 0) model(segs[n], cyc + 1);
                rst = segs[n].rst;
                ws  = segs[n].v;
                if (i >= 1 && i <= W) sd = segs[n].w[W-i];
                else sd = 1'($urandom);
            end
            if (segs[n].rst) begin
                @(negedge clk);
                chk("reset_left", lc, 32'd0);
                chk("reset_right", rc, 32'd0);
                chk("reset_flags", {29'b0, pkt, lk, ferr}, 32'd0);
            end
        end
        repeat (5) @(negedge clk);
        chk("pending_events", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
